// File: rtl/lcd_ctrl_pkg.sv
// Shared types and helpers for the HD44780-style LCD write controller.
// Optional feature macro: LCD_LONG_EXEC_EN (long execution wait for clear/home).
package lcd_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        WAIT
    } state_t;

    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_HOME  = 8'h02;

    // Clear (0x00/0x01) and return home (0x02/0x03) need the long execution time.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data_byte);
        return !rs && ((data_byte[7:1] == CMD_CLEAR[7:1]) ||
                       (data_byte[7:1] == CMD_HOME[7:1]));
    endfunction

    function automatic int unsigned max_cyc(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_ctrl_timer.sv
// Loadable down-counter with a done flag; stops at zero and never wraps.
module lcd_ctrl_timer #(
    parameter int unsigned WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             done
);

    logic [WIDTH-1:0] count;

    // Load has priority; otherwise count down until zero and hold there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// Write-only 8-bit parallel controller for an HD44780-style character LCD.
// Accepts a 9-bit {RS, byte} word on valid/ready, emits one timed E pulse,
// then waits out the LCD execution time before becoming ready again.
// Optional feature macro: LCD_LONG_EXEC_EN (clear/home use LONG_EXEC_CYC).
module lcd_ctrl
    import lcd_ctrl_pkg::*;
#(
    parameter int unsigned SETUP_CYC     = 2,
    parameter int unsigned EN_CYC        = 4,
    parameter int unsigned HOLD_CYC      = 2,
    parameter int unsigned EXEC_CYC      = 8,
    parameter int unsigned LONG_EXEC_CYC = 40
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [8:0] data,
    input  logic       data_valid,
    output logic       ready,
    output logic       lcd_rs,
    output logic [7:0] lcd_data,
    output logic       lcd_enable
);

    localparam int unsigned MAX_CYC = max_cyc(max_cyc(max_cyc(SETUP_CYC, EN_CYC),
                                                      max_cyc(HOLD_CYC, EXEC_CYC)),
                                              LONG_EXEC_CYC);
    localparam int unsigned CW = $clog2(MAX_CYC) + 1;

    // Each phase loads N-1: the counter is done on the Nth edge spent in the phase.
    localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] EN_LD    = CW'(EN_CYC - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] EXEC_LD  = CW'(EXEC_CYC - 1);
    localparam logic [CW-1:0] LONG_LD  = CW'(LONG_EXEC_CYC - 1);

    state_t          state, state_next;
    logic            ready_next;
    logic            rs_next;
    logic [7:0]      data_next;
    logic            en_next;
    logic            t_load;
    logic [CW-1:0]   t_val;
    logic            t_done;
    logic [CW-1:0]   wait_ld;

    lcd_ctrl_timer #(
        .WIDTH (CW)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (t_load),
        .load_val (t_val),
        .done     (t_done)
    );

    // Execution wait length, chosen from the latched word (lcd_rs/lcd_data).
    always_comb begin
        wait_ld = EXEC_LD;
`ifdef LCD_LONG_EXEC_EN
        if (is_long_cmd(lcd_rs, lcd_data)) begin
            wait_ld = LONG_LD;
        end
`endif
    end

    // State register and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ready      <= 1'b0;
            lcd_rs     <= 1'b0;
            lcd_data   <= 8'h00;
            lcd_enable <= 1'b0;
        end else begin
            state      <= state_next;
            ready      <= ready_next;
            lcd_rs     <= rs_next;
            lcd_data   <= data_next;
            lcd_enable <= en_next;
        end
    end

    // Next-state and next-output logic; every phase reloads the timer on exit.
    always_comb begin
        state_next = state;
        ready_next = ready;
        rs_next    = lcd_rs;
        data_next  = lcd_data;
        en_next    = lcd_enable;
        t_load     = 1'b0;
        t_val      = '0;

        case (state)
            IDLE: begin
                if (ready && data_valid) begin
                    rs_next    = data[8];
                    data_next  = data[7:0];
                    ready_next = 1'b0;
                    t_load     = 1'b1;
                    t_val      = SETUP_LD;
                    state_next = SETUP;
                end else begin
                    ready_next = 1'b1;
                end
            end
            SETUP: begin
                if (t_done) begin
                    en_next    = 1'b1;
                    t_load     = 1'b1;
                    t_val      = EN_LD;
                    state_next = PULSE;
                end
            end
            PULSE: begin
                if (t_done) begin
                    en_next    = 1'b0;
                    t_load     = 1'b1;
                    t_val      = HOLD_LD;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (t_done) begin
                    t_load     = 1'b1;
                    t_val      = wait_ld;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (t_done) begin
                    ready_next = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                en_next    = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_lcd_ctrl.sv
// Self-checking bench for lcd_ctrl: table-driven single words, back-to-back
// stream, and reset during the enable pulse. Honours LCD_LONG_EXEC_EN.
`timescale 1ns/1ps
module tb_lcd_ctrl;

    localparam int SETUP = 2;
    localparam int EN    = 4;
    localparam int HOLD  = 2;
    localparam int EXEC  = 8;
    localparam int LONG  = 40;
`ifdef LCD_LONG_EXEC_EN
    localparam bit LONG_ON = 1'b1;
`else
    localparam bit LONG_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [8:0] data = '0;
    logic       data_valid = 1'b0;
    logic       ready;
    logic       lcd_rs;
    logic [7:0] lcd_data;
    logic       lcd_enable;

    lcd_ctrl #(
        .SETUP_CYC     (SETUP),
        .EN_CYC        (EN),
        .HOLD_CYC      (HOLD),
        .EXEC_CYC      (EXEC),
        .LONG_EXEC_CYC (LONG)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data       (data),
        .data_valid (data_valid),
        .ready      (ready),
        .lcd_rs     (lcd_rs),
        .lcd_data   (lcd_data),
        .lcd_enable (lcd_enable)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int total  = 0;
    int passed = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int exp_lat(input logic [8:0] w);
        bit long_cmd;
        long_cmd = LONG_ON && !w[8] && (w[7:0] <= 8'h03);
        return SETUP + EN + HOLD + (long_cmd ? LONG : EXEC);
    endfunction

    // Scoreboard: expected {rs, byte} per accepted word, popped on each E rise.
    typedef struct {
        logic       rs;
        logic [7:0] d;
    } exp_t;
    exp_t sb[$];

    bit prev_en   = 1'b0;
    int width     = 0;
    int pulses    = 0;
    int rise_cyc  = 0;

    // Pulse monitor: matches each E pulse to the scoreboard and checks its width.
    always @(negedge clk) begin
        if (rst) begin
            prev_en = 1'b0;
            width   = 0;
        end else begin
            if (lcd_enable && !prev_en) begin
                exp_t e;
                pulses++;
                rise_cyc = cyc;
                width    = 1;
                if (sb.size() == 0) begin
                    check("unexpected_pulse", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("pulse_rs", lcd_rs, e.rs);
                    check("pulse_data", lcd_data, e.d);
                end
            end else if (lcd_enable) begin
                width++;
            end else if (prev_en) begin
                check("pulse_width", width, EN);
            end
            prev_en = lcd_enable;
        end
    end

    task automatic wait_ready(input string name, output bit ok);
        int n = 0;
        while (ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        ok = (ready === 1'b1);
        if (!ok) check(name, 0, 1);
    endtask

    // Single transfer; poke changes data while busy, which must be ignored.
    task automatic send(input logic [8:0] w, input bit poke);
        bit ok;
        int t0;
        wait_ready("send_ready_timeout", ok);
        if (!ok) return;
        data       = w;
        data_valid = 1'b1;
        t0         = cyc + 1;
        sb.push_back('{w[8], w[7:0]});
        @(negedge clk);
        data_valid = 1'b0;
        check("accept_outputs", {ready, lcd_rs, lcd_data}, {1'b0, w});
        if (poke) data = 9'h0FF;
        @(negedge clk);
        if (poke) data = 9'h1AA;
        wait_ready("done_ready_timeout", ok);
        if (ok) begin
            check("ready_latency", cyc - t0, exp_lat(w));
            check("enable_rise", rise_cyc - t0, SETUP);
            check("idle_outputs", {lcd_rs, lcd_data}, w);
        end
    endtask

    typedef struct {
        logic [8:0] word;
        bit         poke;
    } vec_t;

    initial begin
        vec_t       vecs[6];
        logic [8:0] seq[8];
        bit         ok;
        int         p0;
        int         n;

        vecs[0] = '{9'h030, 1'b0};
        vecs[1] = '{9'h101, 1'b1};
        vecs[2] = '{9'h001, 1'b0};
        vecs[3] = '{9'h038, 1'b0};
        vecs[4] = '{9'h003, 1'b0};
        vecs[5] = '{9'h1FF, 1'b0};
        seq = '{9'h002, 9'h007, 9'h005, 9'h005, 9'h006, 9'h103, 9'h102, 9'h101};

        // Reset
        #20;
        check("reset_outputs", {ready, lcd_rs, lcd_data, lcd_enable}, 0);
        #27 rst = 1'b0;
        @(negedge clk);
        check("ready_before_edge", ready, 0);
        @(negedge clk);
        check("ready_after_release", ready, 1);

        // Table-driven single words
        foreach (vecs[i]) send(vecs[i].word, vecs[i].poke);

        // Back-to-back with data_valid held high
        p0 = pulses;
        foreach (seq[i]) begin
            wait_ready("b2b_ready_timeout", ok);
            data       = seq[i];
            data_valid = 1'b1;
            sb.push_back('{seq[i][8], seq[i][7:0]});
            @(negedge clk);
            check("b2b_accept", {ready, lcd_rs, lcd_data}, {1'b0, seq[i]});
        end
        data_valid = 1'b0;
        wait_ready("b2b_end_timeout", ok);
        repeat (3) @(negedge clk);
        check("b2b_pulse_count", pulses - p0, 8);
        check("b2b_scoreboard_empty", sb.size(), 0);

        // Reset in the middle of the enable pulse
        wait_ready("abort_ready_timeout", ok);
        data       = 9'h155;
        data_valid = 1'b1;
        sb.push_back('{1'b1, 8'h55});
        @(negedge clk);
        data_valid = 1'b0;
        n = 0;
        while (lcd_enable !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("abort_enable_seen", lcd_enable, 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_async_outputs", {ready, lcd_rs, lcd_data, lcd_enable}, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("abort_ready_after_release", ready, 1);
        p0 = pulses;
        repeat (30) @(negedge clk);
        check("abort_no_residual_pulse", pulses - p0, 0);
        check("abort_enable_low", lcd_enable, 0);

        // Transfer after abort still works
        send(9'h00C, 1'b0);
        check("final_scoreboard_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
